mutex_buffer_sched: RTL

- Frame-buffer ownership scheduler for one video writer and C_READER_NUM readers. The pool holds C_READER_NUM+2 buffers.
- A frame is published to readers only after the writer signals end-of-frame. An aborted frame (a new SOF without an EOF) is discarded and never published.
- Buffer addresses are computed from a base and a stride. The block sits between the stream-to-memory writer, the memory-to-stream readers, and the CPU, which gets the interrupt and status counters.

---
 rtl/mutex_buffer_pkg.sv | 32 +++
 rtl/mutex_buffer_pick.sv | 38 +++
 rtl/mutex_buffer_sched.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mutex_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mutex_buffer_pkg
// Purpose  : Shared definitions for the frame-buffer ownership scheduler:
//            writer state encoding, reader count ceiling, index width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mutex_buffer_pkg;

    typedef enum logic [0:0] {
        W_IDLE   = 1'b0,
        W_ACTIVE = 1'b1
    } wstate_t;

    localparam int MAX_READERS = 6;

    // Ceiling log2, used for elaboration-time width computation.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Buffer index width sized for the largest legal pool.
    localparam int IDX_WIDTH = clog2(MAX_READERS + 2);

endpackage
`default_nettype wire

// File: rtl/mutex_buffer_pick.sv
`default_nettype none
// ============================================================================
// Module   : mutex_buffer_pick
// Purpose  : Combinational lowest-index picker over a free-buffer bitmap.
// Ports    : free_i   - bitmap of free buffers
//            onehot_o - one-hot of the lowest free buffer (0 when none)
//            idx_o    - index of the lowest free buffer (0 when none)
//            none_o   - no buffer is free
// Revision : 1.0 - initial release
// ============================================================================
module mutex_buffer_pick
    import mutex_buffer_pkg::*;
#(
    parameter int C_BUFF_NUM = 4
) (
    input  logic [C_BUFF_NUM-1:0] free_i,
    output logic [C_BUFF_NUM-1:0] onehot_o,
    output logic [IDX_WIDTH-1:0]  idx_o,
    output logic                  none_o
);

    // Scan from the top down so the lowest free index wins last.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        for (int i = C_BUFF_NUM - 1; i >= 0; i--) begin
            if (free_i[i]) begin
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                idx_o       = IDX_WIDTH'(i);
            end
        end
    end

    assign none_o = ~|free_i;

endmodule
`default_nettype wire

// File: rtl/mutex_buffer_sched.sv
`default_nettype none
// ============================================================================
// Module   : mutex_buffer_sched
// Purpose  : Frame-buffer ownership scheduler for one writer and
//            C_READER_NUM readers over a pool of C_READER_NUM+2 buffers.
//            Frames are published on writer EOF; aborted frames are dropped.
// Ports    : clk, resetn          - clock, synchronous active-low reset
//            buf_base, buf_stride - buffer address generation
//            freeze               - suppress publishing of completed frames
//            w_sof, w_eof         - writer frame markers
//            w_addr, w_idx        - writer target buffer
//            r_sof                - per-reader frame start
//            r_addr, r_valid      - per-reader buffer address / validity
//            intr                 - one-cycle pulse per publish
//            frame_cnt, drop_cnt  - saturating publish / abort counters
//            err                  - sticky "no free buffer" flag
// Revision : 1.0 - initial release
// ============================================================================
module mutex_buffer_sched
    import mutex_buffer_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_READER_NUM = 2,
    parameter int C_CNT_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic [C_ADDR_WIDTH-1:0]              buf_base,
    input  logic [C_ADDR_WIDTH-1:0]              buf_stride,
    input  logic                                 freeze,
    input  logic                                 w_sof,
    input  logic                                 w_eof,
    output logic [C_ADDR_WIDTH-1:0]              w_addr,
    output logic [2:0]                           w_idx,
    input  logic [C_READER_NUM-1:0]              r_sof,
    output logic [C_READER_NUM*C_ADDR_WIDTH-1:0] r_addr,
    output logic [C_READER_NUM-1:0]              r_valid,
    output logic                                 intr,
    output logic [C_CNT_WIDTH-1:0]               frame_cnt,
    output logic [C_CNT_WIDTH-1:0]               drop_cnt,
    output logic                                 err
);

    localparam int C_BUFF_NUM = C_READER_NUM + 2;
    localparam int AW         = C_ADDR_WIDTH;

    wstate_t                 w_state_q;
    logic [C_BUFF_NUM-1:0]   w_bmp_q;
    logic [IDX_WIDTH-1:0]    w_idx_q;
    logic [AW-1:0]           w_addr_q;
    logic [C_BUFF_NUM-1:0]   last_bmp_q,   last_bmp_d;
    logic                    last_valid_q, last_valid_d;
    logic [AW-1:0]           last_addr_q,  last_addr_d;
    logic [C_BUFF_NUM-1:0]   r_bmp_q  [C_READER_NUM];
    logic [AW-1:0]           r_addr_q [C_READER_NUM];
    logic [C_READER_NUM-1:0] r_valid_q;
    logic                    intr_q;
    logic                    err_q;
    logic [C_CNT_WIDTH-1:0]  frame_cnt_q;
    logic [C_CNT_WIDTH-1:0]  drop_cnt_q;

    logic                    w_active, w_done, w_pub, w_abort;
    logic [C_BUFF_NUM-1:0]   r_busy, free_bmp;
    logic [C_BUFF_NUM-1:0]   pick_onehot, alloc_bmp;
    logic [IDX_WIDTH-1:0]    pick_idx, alloc_idx;
    logic                    pick_none;
    logic [AW-1:0]           alloc_addr;

    assign w_active = (w_state_q == W_ACTIVE);
    assign w_done   = w_active && w_eof;
    assign w_pub    = w_done && !freeze;
    assign w_abort  = w_active && w_sof && !w_eof;

    // "Next" view of the published buffer: a same-cycle publish is visible
    // both to readers starting a frame and to the free-set computation.
    assign last_bmp_d   = w_pub ? w_bmp_q  : last_bmp_q;
    assign last_valid_d = w_pub ? 1'b1     : last_valid_q;
    assign last_addr_d  = w_pub ? w_addr_q : last_addr_q;

    always_comb begin
        r_busy = '0;
        for (int i = 0; i < C_READER_NUM; i++) begin
            r_busy = r_busy | r_bmp_q[i];
        end
    end

    // The writer's own buffer is deliberately not excluded: on abort it may
    // be reused immediately.
    assign free_bmp = ~(last_bmp_d | r_busy);

    mutex_buffer_pick #(
        .C_BUFF_NUM (C_BUFF_NUM)
    ) u_pick (
        .free_i   (free_bmp),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .none_o   (pick_none)
    );

    // Defensive fallback to buffer 0 when the pool is exhausted.
    assign alloc_bmp  = pick_none ? {{(C_BUFF_NUM-1){1'b0}}, 1'b1} : pick_onehot;
    assign alloc_idx  = pick_none ? '0 : pick_idx;
    assign alloc_addr = buf_base + (AW'(alloc_idx) * buf_stride);

    // Writer FSM, publish bookkeeping and counters.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state_q    <= W_IDLE;
            w_bmp_q      <= '0;
            w_idx_q      <= '0;
            w_addr_q     <= '0;
            last_bmp_q   <= '0;
            last_valid_q <= 1'b0;
            last_addr_q  <= '0;
            intr_q       <= 1'b0;
            err_q        <= 1'b0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
        end else begin
            intr_q       <= w_pub;
            last_bmp_q   <= last_bmp_d;
            last_valid_q <= last_valid_d;
            last_addr_q  <= last_addr_d;
            if (w_pub && (frame_cnt_q != '1)) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
            if (w_abort && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
            if (w_sof) begin
                // Covers start from idle, abort, and EOF+SOF back-to-back.
                w_state_q <= W_ACTIVE;
                w_bmp_q   <= alloc_bmp;
                w_idx_q   <= alloc_idx;
                w_addr_q  <= alloc_addr;
                if (pick_none) begin
                    err_q <= 1'b1;
                end
            end else if (w_done) begin
                w_state_q <= W_IDLE;
                w_bmp_q   <= '0;
            end
        end
    end

    // Readers latch the (possibly just-published) last buffer on their SOF.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid_q <= '0;
            for (int i = 0; i < C_READER_NUM; i++) begin
                r_bmp_q[i]  <= '0;
                r_addr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < C_READER_NUM; i++) begin
                if (r_sof[i]) begin
                    r_bmp_q[i]   <= last_bmp_d;
                    r_valid_q[i] <= last_valid_d;
                    r_addr_q[i]  <= last_valid_d ? last_addr_d : '0;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < C_READER_NUM; g++) begin : g_raddr
            assign r_addr[g*AW +: AW] = r_addr_q[g];
        end
    endgenerate

    assign w_addr    = w_addr_q;
    assign w_idx     = 3'(w_idx_q);
    assign r_valid   = r_valid_q;
    assign intr      = intr_q;
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign err       = err_q;

endmodule
`default_nettype wire
